// File: rtl/seq_mult_param_pkg.sv
// mult_pkg: operand-mode encodings and FSM state type for seq_mult_param
package mult_pkg;
  typedef enum logic [1:0] {
    MODE_UU  = 2'b00,
    MODE_SS  = 2'b01,
    MODE_SU  = 2'b10,
    MODE_RSV = 2'b11
  } mode_t;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;
endpackage

// File: rtl/seq_mult_param_fulladder_n.sv
// fulladder_n: N-bit ripple-carry adder
//   a, b : N-bit addends    cin  : carry in
//   sum  : N-bit sum        cout : carry out
module fulladder_n #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[N];
endmodule

// File: rtl/seq_mult_param.sv
// seq_mult_param: iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, with start/busy/done handshake
//   clk, rst_n (async active-low) | start, mode[1:0], a, b : request
//   busy, done, higher, lower : status and registered product
//   SEQ_MULT_ZERO_BYPASS_EN : zero operand skips the iteration phase
module seq_mult_param
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lower,
  output logic [WIDTH-1:0] higher
);
  state_t state, state_nx;
  mode_t m;
  logic [WIDTH-1:0] mcand, mplier, acc, sum, addend, mag_a, mag_b;
  logic [CNT_W-1:0] count;
  logic [2*WIDTH-1:0] prod;
  logic neg, carry, sgn_a, sgn_b, byp, last;
  assign m     = mode_t'(mode);
  assign sgn_a = (m == MODE_SS || m == MODE_SU) && a[WIDTH-1];
  assign sgn_b = m == MODE_SS && b[WIDTH-1];
  // unsigned WIDTH-bit magnitude: -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is exact
  assign mag_a = sgn_a ? -a : a;
  assign mag_b = sgn_b ? -b : b;
  assign last  = count == CNT_W'(WIDTH - 1);
`ifdef SEQ_MULT_ZERO_BYPASS_EN
  assign byp = a == '0 || b == '0;
`else
  assign byp = 1'b0;
`endif
  assign addend = mplier[0] ? mcand : '0;
  fulladder_n #(.N(WIDTH)) u_add (
    .a   (acc),
    .b   (addend),
    .cin (1'b0),
    .sum (sum),
    .cout(carry)
  );
  assign prod = neg ? -{acc, mplier} : {acc, mplier};
  always_comb begin
    state_nx = state;
    state_nx = state == S_IDLE ? (start ? (byp ? S_FIX : S_CALC) : S_IDLE) :
               state == S_CALC ? (last ? S_FIX : S_CALC) : S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      lower  <= '0;
      higher <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      neg    <= 1'b0;
    end else begin
      done <= state == S_FIX;
      // stays high through the done cycle; a start in that cycle keeps it high
      busy <= state == S_IDLE ? start : 1'b1;
      if (state == S_IDLE && start) begin
        mcand  <= mag_a;
        mplier <= byp ? '0 : mag_b;
        neg    <= !byp && (sgn_a ^ sgn_b);
        acc    <= '0;
        count  <= '0;
      end else if (state == S_CALC) begin
        {acc, mplier} <= {carry, sum, mplier[WIDTH-1:1]};
        count         <= count + CNT_W'(1);
      end else if (state == S_FIX) begin
        {higher, lower} <= prod;
      end
    end
endmodule
